// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot sequencer for the core's writable instruction memory. While the core is
// held it receives a framed image over a byte stream:
//   SYNC, LEN_LO, LEN_HI, N*4 data bytes (little-endian words), CSUM
// Each word is written to instruction memory with a one-cycle write pulse.
// The checksum is the 8-bit sum of the two length bytes and all data bytes.
// A good checksum releases the core; any failure parks in ERR until the next
// sync byte arrives.
module imem_boot_loader #(
    parameter int          DEPTH_W     = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               rxValid,
    input  logic [7:0]         rxData,
    output logic               rxReady,
    input  logic               bootReq,
    output logic               imWe,
    output logic [DEPTH_W-1:0] imAddr,
    output logic [31:0]        imData,
    output logic               coreHold,
    output logic               done,
    output logic               error,
    output logic [15:0]        wordCount
);

    localparam logic [2:0] ST_WAIT_SYNC = 3'd0;
    localparam logic [2:0] ST_LEN0      = 3'd1;
    localparam logic [2:0] ST_LEN1      = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_CSUM      = 3'd4;
    localparam logic [2:0] ST_RUN       = 3'd5;
    localparam logic [2:0] ST_ERR       = 3'd6;

    // Idle counter only needs to hold TIMEOUT_CYC-1; expiry is detected when a
    // further idle cycle would reach TIMEOUT_CYC.
    localparam int               IDLE_W    = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** DEPTH_W);

    logic [2:0]         state_q,    state_d;
    logic [15:0]        len_q,      len_d;
    logic [7:0]         sum_q,      sum_d;
    logic [1:0]         byteIdx_q,  byteIdx_d;
    logic [23:0]        word_q,     word_d;      // first three bytes of a word
    logic [15:0]        rcvd_q,     rcvd_d;      // words fully received
    logic [IDLE_W-1:0]  idle_q,     idle_d;
    logic               imWe_q,     imWe_d;
    logic [DEPTH_W-1:0] imAddr_q,   imAddr_d;
    logic [31:0]        imData_q,   imData_d;
    logic [15:0]        wordCnt_q,  wordCnt_d;

    logic        accept;
    logic        active;
    logic        timeout;
    logic [15:0] lenFull;

    assign rxReady  = (state_q != ST_RUN);
    assign accept   = rxValid & rxReady;
    assign active   = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign timeout  = active && !accept && (idle_q == IDLE_LAST);
    assign lenFull  = {rxData, len_q[7:0]};

    assign coreHold  = (state_q != ST_RUN);
    assign done      = (state_q == ST_RUN);
    assign error     = (state_q == ST_ERR);
    assign imWe      = imWe_q;
    assign imAddr    = imAddr_q;
    assign imData    = imData_q;
    assign wordCount = wordCnt_q;

    // Next-state logic: frame parsing, word assembly, checksum and timeout.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        byteIdx_d = byteIdx_q;
        word_d    = word_q;
        rcvd_d    = rcvd_q;
        idle_d    = idle_q;
        imWe_d    = 1'b0;
        imAddr_d  = imAddr_q;
        imData_d  = imData_q;
        // The word counter advances at the end of each write pulse so that
        // imAddr equals wordCount while the pulse is high.
        wordCnt_d = wordCnt_q + (imWe_q ? 16'd1 : 16'd0);

        if (active) begin
            idle_d = accept ? '0 : idle_q + 1'b1;
        end

        case (state_q)
            ST_WAIT_SYNC, ST_ERR: begin
                if (accept && (rxData == SYNC_BYTE)) begin
                    state_d   = ST_LEN0;
                    sum_d     = 8'd0;
                    byteIdx_d = 2'd0;
                    idle_d    = '0;
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    len_d[7:0] = rxData;
                    sum_d      = sum_q + rxData;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    len_d[15:8] = rxData;
                    sum_d       = sum_q + rxData;
                    if ((lenFull == 16'd0) || ({1'b0, lenFull} > MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d   = ST_DATA;
                        wordCnt_d = 16'd0;
                        rcvd_d    = 16'd0;
                        byteIdx_d = 2'd0;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sum_d     = sum_q + rxData;
                    word_d    = {rxData, word_q[23:8]};
                    byteIdx_d = byteIdx_q + 2'd1;
                    if (byteIdx_q == 2'd3) begin
                        imWe_d   = 1'b1;
                        imAddr_d = wordCnt_q[DEPTH_W-1:0];
                        imData_d = {rxData, word_q};
                        rcvd_d   = rcvd_q + 16'd1;
                        if ((rcvd_q + 16'd1) == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rxData == sum_q) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN: begin
                if (bootReq) begin
                    state_d = ST_WAIT_SYNC;
                end
            end
            default: begin
                state_d = ST_WAIT_SYNC;
            end
        endcase

        if (timeout) begin
            state_d = ST_ERR;
            idle_d  = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= ST_WAIT_SYNC;
            len_q     <= 16'd0;
            sum_q     <= 8'd0;
            byteIdx_q <= 2'd0;
            word_q    <= 24'd0;
            rcvd_q    <= 16'd0;
            idle_q    <= '0;
            imWe_q    <= 1'b0;
            imAddr_q  <= '0;
            imData_q  <= 32'd0;
            wordCnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            byteIdx_q <= byteIdx_d;
            word_q    <= word_d;
            rcvd_q    <= rcvd_d;
            idle_q    <= idle_d;
            imWe_q    <= imWe_d;
            imAddr_q  <= imAddr_d;
            imData_q  <= imData_d;
            wordCnt_q <= wordCnt_d;
        end
    end

endmodule
